// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the bench-side UART capture receiver.
// The PARITY state exists only when UART_RX_CAPTURE_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int unsigned DataBits  = 8;
    localparam logic        StopLevel = 1'b1;

`ifdef UART_RX_CAPTURE_PARITY_EN
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StParity, StStop, StBreak
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle, StStart, StData, StStop, StBreak
    } state_t;
`endif

    // Value the parity bit must carry so that data plus parity has an even number of ones.
    function automatic logic even_parity(input logic [DataBits-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; head word is visible on rdata whenever not empty.
module uart_rx_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Aw    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [Aw:0]      level
);

    localparam int unsigned Depth = 1 << Aw;

    logic [Width-1:0] mem [Depth];
    logic [Aw:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[Aw] != rd_q[Aw]) && (wr_q[Aw-1:0] == rd_q[Aw-1:0]);
    assign level   = wr_q - rd_q;
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_q[Aw-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[Aw-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_rx_capture.sv
// UART capture receiver: 8N1 deserialiser feeding a show-ahead byte FIFO.
// Define UART_RX_CAPTURE_PARITY_EN for 8E1 frames with parity checking.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [FIFO_AW:0] level_o,
    input  logic             err_clr_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    output logic             parity_err_o
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitM1  = CntW'(CLKS_PER_BIT - 1);

    state_t                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [2:0]            bit_q, bit_d;
    logic [DataBits-1:0]   shift_q, shift_d;
    logic                  rx_meta_q, rx_s;
    logic                  push, frame_set, overrun_set, full, empty;
    logic                  frame_q, overrun_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rx_meta_q <= rx_i;
            rx_s      <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            frame_q   <= frame_set | (frame_q & ~err_clr_i);
            overrun_q <= overrun_set | (overrun_q & ~err_clr_i);
        end
    end

`ifdef UART_RX_CAPTURE_PARITY_EN
    logic par_bad_q, par_bad_d, par_set, par_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            par_bad_q <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            par_bad_q <= par_bad_d;
            par_q     <= par_set | (par_q & ~err_clr_i);
        end
    end
    assign parity_err_o = par_q;
`else
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_CAPTURE_PARITY_EN
        par_bad_d = par_bad_q;
        par_set   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
`ifdef UART_RX_CAPTURE_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == HalfM1) begin
                    cnt_d   = '0;
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == BitM1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DataBits-1:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_CAPTURE_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_CAPTURE_PARITY_EN
            StParity: begin
                if (cnt_q == BitM1) begin
                    cnt_d     = '0;
                    par_bad_d = (even_parity(shift_q) != rx_s);
                    par_set   = par_bad_d;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            StStop: begin
                if (cnt_q == BitM1) begin
                    cnt_d = '0;
                    if (rx_s == StopLevel) begin
`ifdef UART_RX_CAPTURE_PARITY_EN
                        push = ~par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // A line held low past the stop bit counts as one frame error.
                if (rx_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign valid_o     = ~empty;
    assign overrun_set = push & full & ~ready_i;
    assign frame_err_o = frame_q;
    assign overrun_o   = overrun_q;

    uart_rx_fifo #(
        .Width (DataBits),
        .Aw    (FIFO_AW)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push),
        .wdata (shift_q),
        .pop   (ready_i),
        .rdata (data_o),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

endmodule

// File: tb/tb_uart_rx_capture.sv
// Self-checking bench for uart_rx_capture (CLKS_PER_BIT=16, FIFO_AW=2).
// Honours UART_RX_CAPTURE_PARITY_EN when defined at compile time.
module tb_uart_rx_capture;

    localparam int unsigned Cpb = 16;
    localparam int unsigned Aw  = 2;
`ifdef UART_RX_CAPTURE_PARITY_EN
    localparam int unsigned PushOfs = 170;
`else
    localparam int unsigned PushOfs = 154;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [7:0]    data;
    logic          valid, frame_err, overrun, parity_err;
    logic [Aw:0]   level;

    int unsigned   n_pass = 0;
    int unsigned   n_total = 0;
    logic [7:0]    got[$];

    always #5 clk = ~clk;

    uart_rx_capture #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_AW      (Aw)
    ) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .level_o      (level),
        .err_clr_i    (err_clr),
        .frame_err_o  (frame_err),
        .overrun_o    (overrun),
        .parity_err_o (parity_err)
    );

    // Record every accepted head byte, sampled just before the rising edge.
    always begin
        @(negedge clk);
        #4;
        if (valid && ready) got.push_back(data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic par_flip);
        logic [10:0] bits;
        int          nb;
`ifdef UART_RX_CAPTURE_PARITY_EN
        bits = {stop, (^b) ^ par_flip, b, 1'b0};
        nb   = 11;
`else
        bits = {1'b1, stop, b, 1'b0};
        nb   = 10;
        if (par_flip) nb = 10;
`endif
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            idle(Cpb);
        end
        rx = 1'b1;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    typedef struct {
        logic [7:0] byte_v;
        logic       stop;
        int         exp_cnt;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h55, 1'b1, 1, 1'b0};
        vecs[1] = '{8'hA3, 1'b1, 1, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1, 1'b0};
        vecs[3] = '{8'hFF, 1'b1, 1, 1'b0};
        vecs[4] = '{8'h41, 1'b0, 0, 1'b1};

        idle(3);
        check("rst_valid", valid, 0);
        check("rst_level", level, 0);
        check("rst_data", data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        check("rst_perr", parity_err, 0);
        rst = 1'b0;
        idle(4);

        // Single frames, consumer always ready.
        ready = 1'b1;
        foreach (vecs[i]) begin
            got.delete();
            send(vecs[i].byte_v, vecs[i].stop, 1'b0);
            idle(3 * Cpb);
            check($sformatf("v%0d_count", i), got.size(), vecs[i].exp_cnt);
            if (vecs[i].exp_cnt == 1 && got.size() == 1)
                check($sformatf("v%0d_data", i), got[0], vecs[i].byte_v);
            check($sformatf("v%0d_ferr", i), frame_err, vecs[i].exp_ferr);
            check($sformatf("v%0d_level", i), level, 0);
            clear_err();
            idle(1);
            check($sformatf("v%0d_ferr_clr", i), frame_err, 0);
        end

        // Short low glitch must be rejected; a following frame still decodes.
        got.delete();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(3 * Cpb);
        check("glitch_count", got.size(), 0);
        check("glitch_ferr", frame_err, 0);
        send(8'h3C, 1'b1, 1'b0);
        idle(2 * Cpb);
        check("post_glitch_count", got.size(), 1);
        if (got.size() == 1) check("post_glitch_data", got[0], 8'h3C);

        // Overrun: five bytes into a four-deep FIFO with nobody reading.
        ready = 1'b0;
        got.delete();
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), 1'b1, 1'b0);
        idle(2 * Cpb);
        check("ovr_level", level, 4);
        check("ovr_flag", overrun, 1);
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        check("ovr_pop_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < got.size()) check($sformatf("ovr_order%0d", i), got[i], 8'h10 + 8'(i));
        check("ovr_drained", level, 0);
        clear_err();
        idle(1);
        check("ovr_clr", overrun, 0);

        // Full FIFO with a pop landing on the same edge as the push.
        got.delete();
        for (int i = 0; i < 4; i++) send(8'h20 + 8'(i), 1'b1, 1'b0);
        check("same_full", level, 4);
        fork
            send(8'h24, 1'b1, 1'b0);
            begin
                idle(PushOfs);
                ready = 1'b1;
                idle(1);
                ready = 1'b0;
            end
        join
        idle(2 * Cpb);
        check("same_level", level, 4);
        check("same_ovr", overrun, 0);
        check("same_pop_count", got.size(), 1);
        ready = 1'b1;
        idle(10);
        ready = 1'b0;
        check("same_total", got.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got.size()) check($sformatf("same_order%0d", i), got[i], 8'h20 + 8'(i));

`ifdef UART_RX_CAPTURE_PARITY_EN
        // Bad parity: byte dropped, parity flag set, no framing error.
        got.delete();
        ready = 1'b1;
        send(8'h07, 1'b1, 1'b1);
        idle(2 * Cpb);
        check("par_err", parity_err, 1);
        check("par_drop", got.size(), 0);
        check("par_ferr", frame_err, 0);
        clear_err();
        idle(1);
        check("par_clr", parity_err, 0);
`else
        check("par_tied", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
